// File: rtl/rf_write_arbiter.sv
// Write-port sequencer for the 16x16 register file: two one-entry writeback buffers
// (A = ALU, B = memory fill), round-robin commit, read-select decode, forwarding and pending scoreboard.
module rf_write_arbiter #(
    parameter int NREG  = 16,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [3:0]       a_addr,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [3:0]       b_addr,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    input  logic [3:0]       rd_addr1,
    input  logic [3:0]       rd_addr2,
    output logic [NREG-1:0]  write_reg,
    output logic [WIDTH-1:0] wr_data,
    output logic [NREG-1:0]  rden1,
    output logic [NREG-1:0]  rden2,
    output logic             fwd1_hit,
    output logic             fwd2_hit,
    output logic [WIDTH-1:0] fwd_data,
    output logic [NREG-1:0]  pending
);

    typedef enum logic [1:0] {IDLE, ONE, BOTH} arb_state_t;

    localparam logic [NREG-1:0] R0_MASK = {{(NREG-1){1'b1}}, 1'b0};

    function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    arb_state_t       arb_state;
    logic             a_vld, b_vld;
    logic [3:0]       a_addr_q, b_addr_q;
    logic [WIDTH-1:0] a_data_q, b_data_q;
    logic             a_young, b_young;
    logic             rr, rr_next;
    logic             commit_a, commit_b, commit;
    logic             a_take, b_take;
    logic [3:0]       c_addr;
    logic [WIDTH-1:0] c_data;

    // Arbitration decision; rr = 1 means B is next for different-address contention.
    always_comb begin
        commit_a  = 1'b0;
        commit_b  = 1'b0;
        rr_next   = rr;
        arb_state = IDLE;
        if (a_vld && b_vld)
            arb_state = BOTH;
        else if (a_vld || b_vld)
            arb_state = ONE;
        case (arb_state)
            IDLE: ;
            ONE: begin
                commit_a = a_vld;
                commit_b = b_vld;
            end
            BOTH: begin
                if (a_addr_q == b_addr_q) begin
                    // A young bit marks the later capture; a tie means same-cycle capture, A goes first.
                    if (a_young && !b_young)
                        commit_b = 1'b1;
                    else
                        commit_a = 1'b1;
                end else begin
                    commit_a = !rr;
                    commit_b = rr;
                    rr_next  = !rr;
                end
            end
            default: ;
        endcase
    end

    assign commit  = commit_a | commit_b;
    assign a_ready = !a_vld | commit_a;
    assign b_ready = !b_vld | commit_b;
    assign a_take  = a_valid & a_ready;
    assign b_take  = b_valid & b_ready;
    assign c_addr  = commit_b ? b_addr_q : a_addr_q;
    assign c_data  = commit_b ? b_data_q : a_data_q;

    always_comb begin
        write_reg = '0;
        wr_data   = '0;
        if (commit) begin
            wr_data = c_data;
            if (c_addr != 4'd0)
                write_reg = onehot(c_addr);
        end
    end

    assign fwd_data = wr_data;
    assign fwd1_hit = commit && (c_addr != 4'd0) && (c_addr == rd_addr1);
    assign fwd2_hit = commit && (c_addr != 4'd0) && (c_addr == rd_addr2);
    assign rden1    = onehot(rd_addr1);
    assign rden2    = onehot(rd_addr2);
    assign pending  = ((a_vld ? onehot(a_addr_q) : '0) | (b_vld ? onehot(b_addr_q) : '0)) & R0_MASK;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_vld    <= 1'b0;
            b_vld    <= 1'b0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            a_data_q <= '0;
            b_data_q <= '0;
            a_young  <= 1'b0;
            b_young  <= 1'b0;
            rr       <= 1'b0;
        end else begin
            rr <= rr_next;
            // A capture is younger only if the other entry survives this edge.
            if (a_take) begin
                a_vld    <= 1'b1;
                a_addr_q <= a_addr;
                a_data_q <= a_data;
                a_young  <= b_vld & !commit_b;
            end else begin
                if (commit_a)
                    a_vld <= 1'b0;
                if (b_take)
                    a_young <= 1'b0;
            end
            if (b_take) begin
                b_vld    <= 1'b1;
                b_addr_q <= b_addr;
                b_data_q <= b_data;
                b_young  <= a_vld & !commit_a;
            end else begin
                if (commit_b)
                    b_vld <= 1'b0;
                if (a_take)
                    b_young <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, hand sequences for fairness and reset,
// then random traffic against a timestamp-based arbitration model.
module tb_rf_write_arbiter;

    logic        clk, rst;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [3:0]  a_addr, b_addr, rd_addr1, rd_addr2;
    logic [15:0] a_data, b_data, wr_data, fwd_data;
    logic [15:0] write_reg, rden1, rden2, pending;
    logic        fwd1_hit, fwd2_hit;

    int checks = 0;
    int failures = 0;

    rf_write_arbiter #(.NREG(16), .WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .write_reg(write_reg), .wr_data(wr_data), .rden1(rden1), .rden2(rden2),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each buffer slot carries its capture cycle; older capture wins on equal address.
    logic        mv[2];
    logic [3:0]  maddr[2];
    logic [15:0] mdata[2];
    int          mts[2];
    logic        mrr;
    int          cyc;
    logic [15:0] mreg[16];
    logic [15:0] dreg[16];

    logic [15:0] s_write_reg, s_wr_data, s_pending;
    logic        s_a_ready, s_b_ready, s_fwd1, s_fwd2;

    typedef struct {
        logic av; logic [3:0] aa; logic [15:0] ad;
        logic bv; logic [3:0] ba; logic [15:0] bd;
        logic [3:0] r1; logic [3:0] r2;
        logic [15:0] wreg; logic [15:0] wdata;
        logic ar; logic br; logic [15:0] pend; logic f1; logic f2;
    } vec_t;
    vec_t vecs[11];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mv[0] = 1'b0; mv[1] = 1'b0;
        mrr = 1'b0;
    endtask

    // Called at posedge+1: drive, sample mid-cycle against the model, then advance the model on the edge.
    task automatic applyStimulus(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                                 input logic bv, input logic [3:0] ba, input logic [15:0] bd,
                                 input logic [3:0] r1, input logic [3:0] r2);
        int c;
        logic [3:0]  caddr;
        logic [15:0] cdata, e_wr, e_wd, e_pend;
        logic e_ar, e_br, e_f1, e_f2;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        rd_addr1 = r1; rd_addr2 = r2;
        @(negedge clk);
        c = -1;
        if (mv[0] && mv[1]) begin
            if (maddr[0] == maddr[1]) c = (mts[1] < mts[0]) ? 1 : 0;
            else c = mrr ? 1 : 0;
        end else if (mv[0]) c = 0;
        else if (mv[1]) c = 1;
        caddr = 4'd0; cdata = 16'h0; e_wr = 16'h0; e_wd = 16'h0;
        if (c >= 0) begin
            caddr = maddr[c];
            cdata = mdata[c];
            e_wd  = cdata;
            if (caddr != 4'd0) e_wr = 16'h1 << caddr;
        end
        e_pend = 16'h0;
        for (int i = 0; i < 2; i++)
            if (mv[i] && maddr[i] != 4'd0) e_pend[maddr[i]] = 1'b1;
        e_ar = !mv[0] || (c == 0);
        e_br = !mv[1] || (c == 1);
        e_f1 = (c >= 0) && (caddr != 4'd0) && (caddr == r1);
        e_f2 = (c >= 0) && (caddr != 4'd0) && (caddr == r2);
        checkOutput("m_write_reg", write_reg, e_wr);
        checkOutput("m_wr_data", wr_data, e_wd);
        checkOutput("m_fwd_data", fwd_data, e_wd);
        checkOutput("m_a_ready", a_ready, e_ar);
        checkOutput("m_b_ready", b_ready, e_br);
        checkOutput("m_pending", pending, e_pend);
        checkOutput("m_rden1", rden1, 16'h1 << r1);
        checkOutput("m_rden2", rden2, 16'h1 << r2);
        checkOutput("m_fwd1", fwd1_hit, e_f1);
        checkOutput("m_fwd2", fwd2_hit, e_f2);
        s_write_reg = write_reg; s_wr_data = wr_data; s_pending = pending;
        s_a_ready = a_ready; s_b_ready = b_ready; s_fwd1 = fwd1_hit; s_fwd2 = fwd2_hit;
        for (int i = 0; i < 16; i++)
            if (write_reg[i]) dreg[i] = wr_data;
        @(posedge clk);
        if (c >= 0) begin
            if (caddr != 4'd0) mreg[caddr] = cdata;
            if (mv[0] && mv[1] && maddr[0] != maddr[1]) mrr = (c == 0);
            mv[c] = 1'b0;
        end
        if (av && e_ar) begin mv[0] = 1'b1; maddr[0] = aa; mdata[0] = ad; mts[0] = cyc; end
        if (bv && e_br) begin mv[1] = 1'b1; maddr[1] = ba; mdata[1] = bd; mts[1] = cyc; end
        cyc++;
        #1;
    endtask

    initial begin
        logic [15:0] qa[$];
        logic [15:0] qb[$];
        logic [15:0] exp_d;
        logic ea, eb, xa, xb;
        logic [15:0] ew;
        int k;

        rst = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; a_addr = 4'd0; b_addr = 4'd0;
        a_data = 16'h0; b_data = 16'h0; rd_addr1 = 4'd0; rd_addr2 = 4'd0;
        cyc = 0;
        for (int i = 0; i < 16; i++) begin mreg[i] = 16'h0; dreg[i] = 16'h0; end
        modelReset();

        #12;
        checkOutput("rst_write_reg", write_reg, 16'h0);
        checkOutput("rst_wr_data", wr_data, 16'h0);
        checkOutput("rst_pending", pending, 16'h0);
        checkOutput("rst_a_ready", a_ready, 1'b1);
        checkOutput("rst_b_ready", b_ready, 1'b1);
        checkOutput("rst_fwd", {fwd1_hit, fwd2_hit}, 2'b00);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        //                 av  aa     ad        bv  ba     bd        r1     r2     wreg      wdata     ar    br    pend      f1    f2
        vecs[0]  = '{1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 16'h0000, 4'd5,  4'd0,  16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd5,  4'd5,  16'h0020, 16'h1234, 1'b1, 1'b1, 16'h0020, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'hFFFF, 4'd0,  4'd0,  16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd0,  4'd0,  16'h0000, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 4'd7, 16'hAAAA, 1'b1, 4'd7, 16'hBBBB, 4'd7,  4'd3,  16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd7,  4'd7,  16'h0080, 16'hAAAA, 1'b1, 1'b0, 16'h0080, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd7,  4'd2,  16'h0080, 16'hBBBB, 1'b1, 1'b1, 16'h0080, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd9, 16'h0B0B, 4'd9,  4'd1,  16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 4'd9, 16'h0A0A, 1'b0, 4'd0, 16'h0000, 4'd9,  4'd1,  16'h0200, 16'h0B0B, 1'b1, 1'b1, 16'h0200, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd9,  4'd9,  16'h0200, 16'h0A0A, 1'b1, 1'b1, 16'h0200, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd0,  4'd15, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};

        for (int v = 0; v < 11; v++) begin
            applyStimulus(vecs[v].av, vecs[v].aa, vecs[v].ad, vecs[v].bv, vecs[v].ba, vecs[v].bd,
                          vecs[v].r1, vecs[v].r2);
            checkOutput($sformatf("vec%0d_write_reg", v), s_write_reg, vecs[v].wreg);
            checkOutput($sformatf("vec%0d_wr_data", v), s_wr_data, vecs[v].wdata);
            checkOutput($sformatf("vec%0d_a_ready", v), s_a_ready, vecs[v].ar);
            checkOutput($sformatf("vec%0d_b_ready", v), s_b_ready, vecs[v].br);
            checkOutput($sformatf("vec%0d_pending", v), s_pending, vecs[v].pend);
            checkOutput($sformatf("vec%0d_fwd", v), {s_fwd1, s_fwd2}, {vecs[v].f1, vecs[v].f2});
        end
        checkOutput("final_r5", dreg[5], 16'h1234);
        checkOutput("final_r7_b_last", dreg[7], 16'hBBBB);
        checkOutput("final_r9_a_last", dreg[9], 16'h0A0A);
        checkOutput("r0_never_written", dreg[0], 16'h0000);

        // Both requesters streaming to different registers: commits alternate A, B, ...
        for (k = 0; k < 23; k++) begin
            xa = (k < 20); xb = (k < 20);
            if (k <= 20) begin
                ea = (k == 0) || (k % 2 == 1);
                eb = (k == 0) || (k % 2 == 0);
            end else begin
                ea = 1'b1; eb = 1'b1;
            end
            ew = 16'h0;
            if (k != 0 && k != 22) ew = (k % 2 == 1) ? 16'h0008 : 16'h0010;
            applyStimulus(xa, 4'd3, 16'(k), xb, 4'd4, 16'(16'h100 + k), 4'd3, 4'd4);
            checkOutput($sformatf("rr%0d_write_reg", k), s_write_reg, ew);
            checkOutput($sformatf("rr%0d_a_ready", k), s_a_ready, ea);
            checkOutput($sformatf("rr%0d_b_ready", k), s_b_ready, eb);
            if (ew == 16'h0008) begin
                exp_d = (qa.size() > 0) ? qa.pop_front() : 16'hDEAD;
                checkOutput($sformatf("rr%0d_a_data", k), s_wr_data, exp_d);
            end else if (ew == 16'h0010) begin
                exp_d = (qb.size() > 0) ? qb.pop_front() : 16'hDEAD;
                checkOutput($sformatf("rr%0d_b_data", k), s_wr_data, exp_d);
            end
            if (xa && ea) qa.push_back(16'(k));
            if (xb && eb) qb.push_back(16'(16'h100 + k));
        end
        checkOutput("rr_a_none_lost", qa.size(), 0);
        checkOutput("rr_b_none_lost", qb.size(), 0);

        // Reset asserted between edges with both buffers full.
        applyStimulus(1'b1, 4'd3, 16'h3333, 1'b1, 4'd4, 16'h4444, 4'd3, 4'd4);
        a_valid = 1'b0; b_valid = 1'b0;
        checkOutput("pre_rst_pending", pending, 16'h0018);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_write_reg", write_reg, 16'h0);
        checkOutput("midrst_wr_data", wr_data, 16'h0);
        checkOutput("midrst_pending", pending, 16'h0);
        checkOutput("midrst_ready", {a_ready, b_ready}, 2'b11);
        checkOutput("midrst_fwd", {fwd1_hit, fwd2_hit}, 2'b00);
        modelReset();
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd3, 4'd4);
        checkOutput("post_rst_no_commit", s_write_reg, 16'h0);
        checkOutput("post_rst_no_data", s_wr_data, 16'h0);

        // Random traffic; narrow address range half the time to force same-address contention.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] ra, rb;
            ra = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 3) != 0, ra, 16'($urandom),
                          $urandom_range(0, 3) != 0, rb, 16'($urandom),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        for (int d = 0; d < 3; d++)
            applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("regfile_r%0d", i), dreg[i], mreg[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Sequencing and arbitration block for the 16-entry, 16-bit register file built from `register` instances. Two writeback requesters share the file's single write port: requester A is ALU writeback and requester B is memory/cache-fill writeback. Each requester has a one-entry holding buffer, and a fair round-robin arbiter commits one write per cycle. The block also drives the one-hot `write_reg`, `rden1` and `rden2` selects for all 16 registers, forwards same-cycle writes to both read ports, and keeps a pending-write scoreboard.

## Interface
- `NREG`, 16, number of registers; one-hot select width.
- `WIDTH`, 16, data width.
- `clk` input 1: sole clock; all state changes on the rising edge.
- `rst` input 1: reset; asynchronous, active-low.
- `a_valid` input 1: requester A has a write.
- `a_addr` input 4: A target register.
- `a_data` input WIDTH: A write data.
- `a_ready` output 1: A buffer can accept this cycle.
- `b_valid` input 1: requester B has a write.
- `b_addr` input 4: B target register.
- `b_data` input WIDTH: B write data.
- `b_ready` output 1: B buffer can accept this cycle.
- `rd_addr1` input 4: read port 1 register index.
- `rd_addr2` input 4: read port 2 register index.
- `write_reg` output NREG: one-hot per-register write enable.
- `wr_data` output WIDTH: data driven to every register's `d` input.
- `rden1` output NREG: one-hot read select, port 1.
- `rden2` output NREG: one-hot read select, port 2.
- `fwd1_hit` output 1: commit this cycle targets `rd_addr1`.
- `fwd2_hit` output 1: commit this cycle targets `rd_addr2`.
- `fwd_data` output WIDTH: the committing data; equals `wr_data`.
- `pending` output NREG: bit i set while any buffered write targets register i.

## Operation
- **Buffers.** Each requester has one buffer holding valid, addr, data and an age bit.
  - A handshake occurs when `x_valid & x_ready`; the request is captured at that clock edge.
  - `x_ready = !buf_valid | commit_this_buf`, so the block accepts back-to-back requests at full rate.
- **Arbiter states.**
  - IDLE: no buffer valid; no commit.
  - ONE: exactly one buffer valid; that buffer commits.
  - BOTH: both buffers valid; select per the rules below.
- **Selection in BOTH.**
  - Different addresses: round-robin pointer `rr`. The buffer `rr` names commits, then `rr` flips to the other requester.
  - Same address: the older entry commits first. Age bit is set when the other buffer was already valid at capture.
  - Same address, captured the same cycle: A commits first and B second, so B's value is final. `rr` is not updated.
- **Write port.** On a commit:
  - `write_reg` is the one-hot decode of the committing addr.
  - `wr_data` is the committing data.
  - The buffer clears at the edge unless refilled by a handshake in the same cycle.
  - With no commit, `write_reg` = 0 and `wr_data` = 0.
- **R0.** A commit to register 0 occurs (buffer drains, `x_ready` behaves normally), but `write_reg` stays 0 and `fwd*_hit` stays 0. `pending[0]` is always 0.
- **Reads.** `rden1` and `rden2` are combinational one-hot decodes of `rd_addr1` and `rd_addr2`, always exactly one bit set.
- **Forwarding.** `fwdN_hit` = commit & (addr == `rd_addrN`) & (addr != 0).
- **Scoreboard.** `pending` is the OR of the one-hot decodes of both valid buffer addresses, computed from registered state only.

## Timing
- **Reset (rst low, any time):**
  - Buffers invalid; `rr` = A; age bits cleared.
  - `a_ready` = `b_ready` = 1.
  - `write_reg`, `wr_data`, `pending`, `fwd*_hit`, `fwd_data` = 0.
  - A write in flight is discarded with no partial commit.
- **First cycle after reset deassertion:** behaves as IDLE.
- **Latency:** handshake in cycle t, `write_reg` asserted in cycle t+1, register holds the new value from the edge ending t+1. A read in t+1 gets the value through `fwd*`; a read in t+2 gets it from the register file.
- **Throughput:** one commit per cycle. With both requesters streaming continuously, each gets one commit every 2 cycles, and `x_ready` toggles accordingly.
- **Simultaneous refill:** a buffer committing and accepting in the same cycle holds the new entry in the next cycle. `pending` reflects that new entry.
- **Outputs from registered state:** `pending`, `write_reg` and `wr_data` depend only on registered state. `x_ready` additionally depends on the arbiter decision and never on `x_valid`.

## Test plan
- **Single write:** reset, release; A writes addr 5, data 0x1234 at t → `write_reg` = 0x0020 and `wr_data` = 0x1234 in t+1; `pending[5]` = 1 only during t+1; `rden1` selects 5 → `fwd1_hit` = 1 in t+1.
- **Round-robin fairness:** A and B both valid every cycle, A to addr 3, B to addr 4 → commits alternate A, B, A, B; each `x_ready` asserted every other cycle; no request lost over 20 cycles.
- **Same-address ordering:** A (addr 7, 0xAAAA) and B (addr 7, 0xBBBB) captured in the same cycle → commit A in t+1, then B in t+2; `pending[7]` stays high through t+2; final value 0xBBBB. Repeat with B captured one cycle before A → B first, final value 0xAAAA.
- **R0 drop:** B writes addr 0, data 0xFFFF → buffer drains in t+1, `b_ready` = 1 in t+1, `write_reg` = 0, `fwd*_hit` = 0, `pending` = 0 throughout.
- **Reset mid-operation:** both buffers full, `rst` driven low between edges → immediately `write_reg` = 0, `pending` = 0, both ready = 1; after release, no stale commit occurs.
